// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the two-byte instruction fetch sequencer.
package instruction_fetch_unit_pkg;

  localparam int DEF_ADDR_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_LO = 2'd1,
    RD_HI = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic LH_LOW  = 1'b0;
  localparam logic LH_HIGH = 1'b1;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Bundle of control, memory and instruction-register signals around the fetch unit.
// Memory handshake: MemRead is held with a stable MemAddr until a cycle with
// MemReady=1; MemData is consumed in that same cycle, and the IR captures it on the next edge.
interface instruction_fetch_unit_if #(
  parameter int ADDR_W = instruction_fetch_unit_pkg::DEF_ADDR_W
);
  logic              FetchStart;
  logic              PCLoad;
  logic [ADDR_W-1:0] PCIn;
  logic [ADDR_W-1:0] MemAddr;
  logic              MemRead;
  logic              MemReady;
  logic [7:0]        MemData;
  logic [7:0]        IRData;
  logic              IRWrite;
  logic              IRLH;
  logic [ADDR_W-1:0] PCOut;
  logic              Busy;
  logic              FetchDone;

  modport master (
    input  FetchStart, PCLoad, PCIn, MemReady, MemData,
    output MemAddr, MemRead, IRData, IRWrite, IRLH, PCOut, Busy, FetchDone
  );

  modport slave (
    output FetchStart, PCLoad, PCIn, MemReady, MemData,
    input  MemAddr, MemRead, IRData, IRWrite, IRLH, PCOut, Busy, FetchDone
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetches a 16-bit instruction as two bytes (low at PC, high at PC+1) and
// streams them into the instruction register, advancing PC per byte.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                     Clock,
  input  logic                     Reset,
  instruction_fetch_unit_if.master bus,
  output state_t                   dbg_state_o
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    bus.MemAddr   = '0;
    bus.MemRead   = 1'b0;
    bus.IRData    = 8'h00;
    bus.IRWrite   = 1'b0;
    bus.IRLH      = LH_LOW;
    bus.FetchDone = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A simultaneous load and start fetches from the new target.
        if (bus.PCLoad)     pc_d    = bus.PCIn;
        if (bus.FetchStart) state_d = RD_LO;
      end
      RD_LO: begin
        bus.MemRead = 1'b1;
        bus.MemAddr = pc_q;
        if (bus.MemReady) begin
          bus.IRWrite = 1'b1;
          bus.IRData  = bus.MemData;
          pc_d        = pc_q + ADDR_W'(1);
          state_d     = RD_HI;
        end
      end
      RD_HI: begin
        bus.MemRead = 1'b1;
        bus.MemAddr = pc_q;
        bus.IRLH    = LH_HIGH;
        if (bus.MemReady) begin
          bus.IRWrite = 1'b1;
          bus.IRData  = bus.MemData;
          pc_d        = pc_q + ADDR_W'(1);
          state_d     = DONE;
        end
      end
      DONE: begin
        bus.FetchDone = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.PCOut   = pc_q;
  assign bus.Busy    = (state_q != IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: byte memory, instruction register and a
// fetch-level reference model (PC, expected IR words, per-cycle timeline).
module tb_instruction_fetch_unit;
  import instruction_fetch_unit_pkg::*;

  localparam int              AW     = 16;
  localparam logic [AW-1:0]   RST_PC = '0;

  logic   Clock = 1'b0;
  logic   Reset = 1'b0;
  state_t dbg_state;

  instruction_fetch_unit_if #(.ADDR_W(AW)) bus();

  instruction_fetch_unit #(.ADDR_W(AW), .RESET_PC(RST_PC)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .bus         (bus.master),
    .dbg_state_o (dbg_state)
  );

  always #5 Clock = ~Clock;

  // Byte-wide memory answering combinationally on the current address.
  logic [7:0] mem [0:65535];
  assign bus.MemData = mem[bus.MemAddr];

  // Instruction register: byte write with low/high select.
  logic [15:0] ir;
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)           ir       <= 16'h0000;
    else if (bus.IRWrite) begin
      if (bus.IRLH)       ir[15:8] <= bus.IRData;
      else                ir[7:0]  <= bus.IRData;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  int done_seen = 0;
  logic [15:0] model_pc;
  logic [15:0] exp_q[$];

  always @(negedge Clock) if (bus.FetchDone === 1'b1) done_seen++;

  task automatic clear_inputs();
    bus.FetchStart = 1'b0;
    bus.PCLoad     = 1'b0;
    bus.PCIn       = '0;
    bus.MemReady   = 1'b0;
  endtask

  // One full fetch following the model timeline: lo_w wait cycles before the
  // low byte, hi_w before the high byte, then one DONE cycle.
  task automatic do_fetch(input bit load, input logic [15:0] pcin, input int lo_w,
                          input int hi_w, input bit poke_busy);
    logic [15:0] start, start_p1, start_p2;
    int n;
    @(negedge Clock);
    n_tests++;
    if (bus.Busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_busy: got %b expected 0", bus.Busy);
    end
    n_tests++;
    if (bus.PCOut !== model_pc) begin
      n_fail++; $display("FAIL idle_pc: got %h expected %h", bus.PCOut, model_pc);
    end
    if (load) model_pc = pcin;
    start    = model_pc;
    start_p1 = start + 16'd1;
    start_p2 = start + 16'd2;
    exp_q.push_back({mem[start_p1], mem[start]});
    bus.FetchStart = 1'b1;
    bus.PCLoad     = load;
    bus.PCIn       = pcin;
    bus.MemReady   = 1'($urandom_range(0, 1));
    n = lo_w + hi_w + 3;
    for (int c = 0; c < n; c++) begin
      bit in_lo, in_hi, in_done, rdy;
      logic [15:0] ea, epc, exp_ir;
      logic [7:0]  ed;
      @(negedge Clock);
      in_lo   = (c <= lo_w);
      in_hi   = !in_lo && (c <= lo_w + 1 + hi_w);
      in_done = !in_lo && !in_hi;
      rdy     = (in_lo && c == lo_w) || (in_hi && c == lo_w + 1 + hi_w);
      ea      = in_lo ? start : (in_hi ? start_p1 : 16'h0000);
      epc     = in_lo ? start : (in_hi ? start_p1 : start_p2);
      ed      = in_lo ? mem[start] : mem[start_p1];
      bus.FetchStart = poke_busy && !in_lo;
      bus.PCLoad     = poke_busy && !in_lo;
      bus.PCIn       = 16'($urandom);
      bus.MemReady   = (in_lo || in_hi) ? rdy : 1'($urandom_range(0, 1));
      #1;
      n_tests++;
      if (bus.Busy !== 1'b1) begin
        n_fail++; $display("FAIL busy c%0d: got %b expected 1", c, bus.Busy);
      end
      n_tests++;
      if (bus.MemRead !== (in_lo || in_hi)) begin
        n_fail++; $display("FAIL memread c%0d: got %b expected %b", c, bus.MemRead, in_lo || in_hi);
      end
      n_tests++;
      if (bus.MemAddr !== ea) begin
        n_fail++; $display("FAIL memaddr c%0d: got %h expected %h", c, bus.MemAddr, ea);
      end
      n_tests++;
      if (bus.IRWrite !== rdy) begin
        n_fail++; $display("FAIL irwrite c%0d: got %b expected %b", c, bus.IRWrite, rdy);
      end
      if (rdy) begin
        n_tests++;
        if (bus.IRLH !== in_hi) begin
          n_fail++; $display("FAIL irlh c%0d: got %b expected %b", c, bus.IRLH, in_hi);
        end
        n_tests++;
        if (bus.IRData !== ed) begin
          n_fail++; $display("FAIL irdata c%0d: got %h expected %h", c, bus.IRData, ed);
        end
      end else begin
        n_tests++;
        if (bus.IRData !== 8'h00) begin
          n_fail++; $display("FAIL irdata_idle c%0d: got %h expected 00", c, bus.IRData);
        end
      end
      n_tests++;
      if (bus.PCOut !== epc) begin
        n_fail++; $display("FAIL pcout c%0d: got %h expected %h", c, bus.PCOut, epc);
      end
      n_tests++;
      if (bus.FetchDone !== in_done) begin
        n_fail++; $display("FAIL fetchdone c%0d: got %b expected %b", c, bus.FetchDone, in_done);
      end
      if (in_done) begin
        exp_ir = exp_q.pop_front();
        n_tests++;
        if (ir !== exp_ir) begin
          n_fail++; $display("FAIL ir_word: got %h expected %h", ir, exp_ir);
        end
      end
    end
    model_pc = start_p2;
  endtask

  task automatic check_idle(input string tag);
    @(negedge Clock);
    clear_inputs();
    #1;
    n_tests++;
    if (bus.Busy !== 1'b0 || dbg_state !== IDLE) begin
      n_fail++; $display("FAIL %s_idle: got busy=%b state=%0d expected busy=0 state=0", tag, bus.Busy, dbg_state);
    end
    n_tests++;
    if (bus.PCOut !== model_pc) begin
      n_fail++; $display("FAIL %s_pc: got %h expected %h", tag, bus.PCOut, model_pc);
    end
    n_tests++;
    if (bus.MemRead !== 1'b0 || bus.MemAddr !== 16'h0 || bus.FetchDone !== 1'b0) begin
      n_fail++; $display("FAIL %s_outs: got rd=%b addr=%h done=%b expected 0/0000/0", tag, bus.MemRead, bus.MemAddr, bus.FetchDone);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    Reset = 1'b0;
    @(negedge Clock);
    n_tests++;
    if ({bus.MemRead, bus.IRWrite, bus.IRLH, bus.Busy, bus.FetchDone} !== 5'b0 ||
        bus.IRData !== 8'h00 || bus.MemAddr !== 16'h0000 || bus.PCOut !== RST_PC) begin
      n_fail++; $display("FAIL reset_outs: got rd=%b wr=%b lh=%b busy=%b done=%b d=%h a=%h pc=%h expected all 0, pc=%h",
        bus.MemRead, bus.IRWrite, bus.IRLH, bus.Busy, bus.FetchDone, bus.IRData, bus.MemAddr, bus.PCOut, RST_PC);
    end
    Reset = 1'b1;
    model_pc = RST_PC;
  endtask

  task automatic test_basic();
    mem[16'h0000] = 8'h34;
    mem[16'h0001] = 8'h12;
    do_fetch(1'b0, 16'h0, 0, 0, 1'b0);
    check_idle("basic");
    n_tests++;
    if (ir !== 16'h1234 || bus.PCOut !== 16'h0002) begin
      n_fail++; $display("FAIL basic_result: got ir=%h pc=%h expected 1234/0002", ir, bus.PCOut);
    end
  endtask

  task automatic test_wait_states();
    do_fetch(1'b1, 16'h0000, 3, 2, 1'b0);
    check_idle("wait");
    n_tests++;
    if (ir !== 16'h1234) begin
      n_fail++; $display("FAIL wait_ir: got %h expected 1234", ir);
    end
  endtask

  task automatic test_load_start();
    mem[16'h0100] = 8'hCD;
    mem[16'h0101] = 8'hAB;
    do_fetch(1'b1, 16'h0100, 0, 0, 1'b0);
    check_idle("load");
    n_tests++;
    if (ir !== 16'hABCD || bus.PCOut !== 16'h0102) begin
      n_fail++; $display("FAIL load_result: got ir=%h pc=%h expected abcd/0102", ir, bus.PCOut);
    end
  endtask

  task automatic test_wrap();
    mem[16'hFFFF] = 8'h5A;
    mem[16'h0000] = 8'hC3;
    do_fetch(1'b1, 16'hFFFF, 0, 1, 1'b0);
    check_idle("wrap");
    n_tests++;
    if (ir !== 16'hC35A || bus.PCOut !== 16'h0001) begin
      n_fail++; $display("FAIL wrap_result: got ir=%h pc=%h expected c35a/0001", ir, bus.PCOut);
    end
  endtask

  task automatic test_ignored_busy();
    int d0;
    d0 = done_seen;
    do_fetch(1'b1, 16'h2000, 1, 2, 1'b1);
    check_idle("busy_ign");
    check_idle("busy_ign2");
    n_tests++;
    if (done_seen - d0 !== 1) begin
      n_fail++; $display("FAIL busy_done_count: got %0d expected 1", done_seen - d0);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 24; i++) begin
      bit ld;
      ld = (i == 0) || ($urandom_range(0, 3) == 0);
      do_fetch(ld, 16'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
    check_idle("b2b");
  endtask

  task automatic test_reset_mid_fetch();
    int d0;
    @(negedge Clock);
    bus.FetchStart = 1'b1;
    bus.MemReady   = 1'b1;
    @(negedge Clock);
    bus.FetchStart = 1'b0;
    @(negedge Clock);
    bus.MemReady = 1'b0;
    d0 = done_seen;
    #2 Reset = 1'b0;
    #1;
    n_tests++;
    if ({bus.MemRead, bus.IRWrite, bus.IRLH, bus.Busy, bus.FetchDone} !== 5'b0 ||
        bus.IRData !== 8'h00 || bus.MemAddr !== 16'h0000 || bus.PCOut !== RST_PC) begin
      n_fail++; $display("FAIL midreset_outs: got rd=%b wr=%b lh=%b busy=%b done=%b d=%h a=%h pc=%h expected all 0, pc=%h",
        bus.MemRead, bus.IRWrite, bus.IRLH, bus.Busy, bus.FetchDone, bus.IRData, bus.MemAddr, bus.PCOut, RST_PC);
    end
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
    repeat (3) @(negedge Clock);
    n_tests++;
    if (done_seen !== d0 || bus.Busy !== 1'b0) begin
      n_fail++; $display("FAIL midreset_nodone: got done=%0d busy=%b expected 0/0", done_seen - d0, bus.Busy);
    end
    model_pc = RST_PC;
    exp_q.delete();
    do_fetch(1'b0, 16'h0, 1, 0, 1'b0);
    check_idle("after_reset");
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    test_reset();
    test_basic();
    test_wait_states();
    test_load_start();
    test_wrap();
    test_ignored_busy();
    test_back_to_back();
    test_reset_mid_fetch();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Two-byte instruction fetch sequencer sitting directly upstream of the 16-bit instruction register. On request it reads the low byte at PC and the high byte at PC+1 from byte-wide memory through a ready handshake. It drives the register's byte input, write enable and load-high select, advances the PC, and signals completion to the control unit.

## Interface
- ADDR_W, 16: PC and memory address width.
- RESET_PC, 0: PC value after reset.

- Clock  in  1  system clock; all state changes on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- FetchStart  in  1  request one 16-bit instruction fetch; sampled only in IDLE.
- PCLoad  in  1  load PC from PCIn; honoured only in IDLE.
- PCIn  in  ADDR_W  branch/jump target.
- MemAddr  out  ADDR_W  memory byte address.
- MemRead  out  1  memory read request.
- MemReady  in  1  MemData valid this cycle.
- MemData  in  8  memory read byte.
- IRData  out  8  byte to instruction register input.
- IRWrite  out  1  instruction register write enable.
- IRLH  out  1  0 = write LSB [7:0], 1 = write MSB [15:8].
- PCOut  out  ADDR_W  current PC.
- Busy  out  1  high in any state except IDLE.
- FetchDone  out  1  one-cycle pulse: full instruction written.

## Operation
- States: IDLE, RD_LO, RD_HI, DONE. Encoding lives in the shared package.
- IDLE:
  - PCLoad=1 sets PC <= PCIn.
  - FetchStart=1 moves to RD_LO.
  - If both are high in the same cycle, the load and the start both take effect, so the fetch begins at PCIn.
- RD_LO:
  - MemRead=1, MemAddr=PC.
  - While MemReady=0, hold state.
  - When MemReady=1: IRWrite=1, IRLH=0, IRData=MemData; PC <= PC+1; go to RD_HI.
- RD_HI:
  - Same handshake with IRLH=1.
  - On MemReady=1: PC <= PC+1; go to DONE.
- DONE: FetchDone=1 for exactly one cycle, then IDLE.
- IRData outputs MemData while IRWrite=1, otherwise 8'h00.
- MemAddr outputs PC in RD_LO/RD_HI, otherwise 0.
- PC arithmetic is modulo 2^ADDR_W: PC of all-ones increments to 0, with no flag.
- PCLoad and FetchStart are ignored while Busy=1. They are not queued.
- MemReady outside RD_LO/RD_HI is ignored.

## Timing
- Reset asserted (low) sets, immediately and independent of Clock:
  - state IDLE, PC = RESET_PC;
  - MemRead, IRWrite, IRLH, Busy, FetchDone = 0;
  - IRData = 0, MemAddr = 0.
- Reset mid-fetch abandons the fetch. No FetchDone pulse is produced, and a partially written IR is left to its own reset.
- Minimum latency, with MemReady held high:
  - FetchStart sampled at edge 0;
  - LSB written at edge 1;
  - MSB written at edge 2;
  - FetchDone high during cycle 3.
  - The next FetchStart is accepted at edge 4 at the earliest.
- Each MemReady=0 cycle in RD_LO/RD_HI adds one cycle. There is no timeout.
- IRWrite and IRLH are Moore/handshake outputs. They are valid in the same cycle as MemReady, and the IR captures on the following edge.
- PCOut is registered and changes on the same edge at which each byte is captured.

## Structure
- Shared package holds:
  - state typedef (IDLE, RD_LO, RD_HI, DONE);
  - IRLH constants LH_LOW=0, LH_HIGH=1;
  - default ADDR_W.
- Single module with a two-process FSM (state register plus next-state/output logic) and a PC register. No sub-module is needed.
- The bench instantiates the existing instruction register on IRData/IRWrite/IRLH with a shared Clock/Reset to check end-to-end capture.

## Test plan
- Basic fetch:
  - Stimulus: reset, memory[0]=8'h34, memory[1]=8'h12, MemReady tied 1, FetchStart pulse.
  - Required: IR=16'h1234 after edge 2, FetchDone in cycle 3, PCOut=2.
- Wait states:
  - Stimulus: MemReady low for 3 cycles in RD_LO and 2 in RD_HI.
  - Required: MemRead and MemAddr held stable, FetchDone 5 cycles later than the basic fetch, same IR value.
- Load plus start:
  - Stimulus: PCLoad=1, PCIn=16'h0100, FetchStart=1 in the same IDLE cycle; memory[0x100]=8'hCD, memory[0x101]=8'hAB.
  - Required: IR=16'hABCD, PCOut=16'h0102.
- Wrap-around:
  - Stimulus: PC loaded to 16'hFFFF, then fetch.
  - Required: LSB read at 16'hFFFF, MSB read at 16'h0000, PCOut=16'h0001.
- Ignored while busy:
  - Stimulus: PCLoad and FetchStart pulsed during RD_HI.
  - Required: PC unaffected by PCIn, exactly one FetchDone, FSM returns to IDLE.
- Reset mid-fetch:
  - Stimulus: Reset pulled low in RD_HI.
  - Required: all outputs 0 immediately, PCOut=RESET_PC, no FetchDone, next fetch works normally.
